alu_issue: RTL and testbench

Pipelined command front-end for the 16-bit barrel-shifter ALU (`alu`). It accepts operation commands over a valid/ready channel and drives them through a registered operand stage into the combinational `alu`. It captures results with their tags in an output FIFO and returns them over a second valid/ready channel. It lets hardware masters, rather than a testbench, drive the ALU at one operation per clock under backpressure.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu.sv | 33 +++
 rtl/alu_rsp_fifo.sv | 53 +++++
 rtl/alu_issue.sv | 99 +++++++++
 tb/tb_alu_issue.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command front-end.
// Op encodings, datapath widths and the operand-stage command bundle.
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int SHIFT_W = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_ROTL = 3'd6;
  localparam logic [2:0] OP_ROTR = 3'd7;

  // Tag travels beside this bundle so its width can stay a parameter.
  typedef struct packed {
    logic [2:0]         op;
    logic [SHIFT_W-1:0] shift;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
  } alu_cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit barrel-shifter ALU.
// Ports: select (op), shift_mag, i0, i1 in; o result out.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]         select,
  input  logic [SHIFT_W-1:0] shift_mag,
  input  logic [DATA_W-1:0]  i0,
  input  logic [DATA_W-1:0]  i1,
  output logic [DATA_W-1:0]  o
);

  logic [4:0] rsh;

  // Complementary shift for rotates; 16 yields zero fill when mag is 0.
  assign rsh = 5'(DATA_W) - {1'b0, shift_mag};

  always_comb begin
    o = '0;
    case (select)
      OP_ADD:  o = i0 + i1;
      OP_SUB:  o = i0 - i1;
      OP_AND:  o = i0 & i1;
      OP_OR:   o = i0 | i1;
      OP_SHL:  o = i0 << shift_mag;
      OP_SHR:  o = i0 >> shift_mag;
      OP_ROTL: o = (i0 << shift_mag) | (i0 >> rsh);
      OP_ROTR: o = (i0 >> shift_mag) | (i0 << rsh);
      default: o = '0;
    endcase
  end

endmodule

// File: rtl/alu_rsp_fifo.sv
// Synchronous circular FIFO with occupancy count, storage reset to 0.
// Ports: clk, rst_n, wr_en/wr_data, rd_en/rd_data, empty, count.
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         full;
  logic         do_wr;
  logic         do_rd;

  // Extra MSB distinguishes full from empty when indices match.
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wptr[AW-1:0]] <= wr_data;
        wptr <= wptr + 1'b1;
      end
      if (do_rd) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Command front-end: operand register -> alu -> tagged result FIFO.
// Ports: cmd_* valid/ready in, rsp_* valid/ready out, busy, op_count.
module alu_issue
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [DATA_W-1:0]  cmd_a,
  input  logic [DATA_W-1:0]  cmd_b,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_zero,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + TAG_W;
  localparam logic [AW+1:0] LIM = (AW+2)'(FIFO_DEPTH);

  alu_cmd_t         s1_cmd;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_valid;
  logic             accept;
  logic             take;
  logic             empty;
  logic [AW:0]      fifo_count;
  logic [AW+1:0]    credit;
  logic [DATA_W-1:0] alu_o;
  logic [EW-1:0]    head;

  // Reserve a slot for the S1 result so S1 never has to stall.
  assign credit    = {1'b0, fifo_count} + {{(AW+1){1'b0}}, s1_valid};
  assign cmd_ready = credit < LIM;
  assign accept    = cmd_valid && cmd_ready;
  assign take      = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cmd   <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_cmd <= '{op: cmd_op, shift: cmd_shift,
                    a: cmd_a, b: cmd_b};
        s1_tag <= cmd_tag;
      end
    end
  end

  alu u_alu (
    .select    (s1_cmd.op),
    .shift_mag (s1_cmd.shift),
    .i0        (s1_cmd.a),
    .i1        (s1_cmd.b),
    .o         (alu_o)
  );

  alu_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s1_valid),
    .wr_data ({alu_o, s1_tag}),
    .rd_en   (take),
    .rd_data (head),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign rsp_valid = !empty;
  assign rsp_data  = head[EW-1:TAG_W];
  assign rsp_tag   = head[TAG_W-1:0];
  assign rsp_zero  = (rsp_data == '0);
  assign busy      = s1_valid || !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (take) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue against an arithmetic reference model.
// Directed steps plus randomized streams; results scoreboarded in order.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_shift = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_zero;
  logic        busy;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  alu_issue #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_shift(cmd_shift),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
  );

  typedef struct {
    int unsigned d;
    int unsigned t;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;
  int takes = 0;
  int issued = 0;
  bit last_acc;
  bit last_take;

  function automatic int unsigned model(int unsigned op, int unsigned s,
                                        int unsigned a, int unsigned b);
    int unsigned p, r;
    p = 1 << s;
    case (op)
      0: r = (a + b) % 65536;
      1: r = (a + 65536 - b) % 65536;
      2: r = a & b;
      3: r = a | b;
      4: r = (a * p) % 65536;
      5: r = a / p;
      6: r = (a * p) % 65536 + a / (65536 / p);
      default: r = a / p + (a * (65536 / p)) % 65536;
    endcase
    return r;
  endfunction

  task automatic chk(string tag, int unsigned obs, int unsigned exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs set; scores handshakes, crosses an edge.
  task automatic tick();
    exp_t e;
    last_acc  = cmd_valid && cmd_ready;
    last_take = rsp_valid && rsp_ready;
    if (last_take) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        e = q.pop_front();
        chk("rsp_data", 32'(rsp_data), e.d);
        chk("rsp_tag", 32'(rsp_tag), e.t);
        chk("rsp_zero", 32'(rsp_zero), 32'(e.d == 0));
        takes++;
      end
    end
    if (last_acc) begin
      e.d = model(cmd_op, cmd_shift, cmd_a, cmd_b);
      e.t = cmd_tag;
      q.push_back(e);
      issued++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(int op, int s, int a, int b, int t);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_shift = 4'(s);
    cmd_a     = 16'(a);
    cmd_b     = 16'(b);
    cmd_tag   = 4'(t);
  endtask

  task automatic rand_cmd();
    drive($urandom_range(7), $urandom_range(15), $urandom_range(65535),
          $urandom_range(65535), $urandom_range(15));
  endtask

  task automatic check_reset_outputs(string pfx);
    chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_rsp_data"}, 32'(rsp_data), 0);
    chk({pfx, "_rsp_tag"}, 32'(rsp_tag), 0);
    chk({pfx, "_rsp_zero"}, 32'(rsp_zero), 1);
    chk({pfx, "_op_count"}, 32'(op_count), 0);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int base;
    int unsigned head_d;
    int unsigned head_t;

    // Reset state
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single add, two-cycle latency
    drive(0, 0, 64, 320, 1);
    tick();
    cmd_valid = 1'b0;
    chk("lat_valid_early", 32'(rsp_valid), 0);
    chk("lat_busy", 32'(busy), 1);
    tick();
    chk("lat_valid", 32'(rsp_valid), 1);
    chk("lat_data", 32'(rsp_data), 384);
    chk("lat_tag", 32'(rsp_tag), 1);
    rsp_ready = 1'b1;
    tick();
    chk("opcnt_1", 32'(op_count), 1);

    // Back-to-back with results on consecutive cycles
    base = takes;
    drive(1, 0, 80, 50, 2);
    tick();
    drive(2, 0, 16'h0032, 16'h0004, 3);
    tick();
    drive(4, 9, 16, 0, 4);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("b2b_takes", takes - base, 3);
    chk("b2b_opcnt", 32'(op_count), 4);
    chk("b2b_empty", 32'(rsp_valid), 0);

    // Backpressure: exactly FIFO_DEPTH accepts, stable head, full drain
    rsp_ready = 1'b0;
    cnt = 0;
    rand_cmd();
    for (int i = 0; i < 20 && cmd_ready; i++) begin
      tick();
      if (last_acc) begin
        cnt++;
        rand_cmd();
      end
    end
    chk("bp_accepts", cnt, 4);
    chk("bp_ready_low", 32'(cmd_ready), 0);
    head_d = rsp_data;
    head_t = rsp_tag;
    tick();
    tick();
    tick();
    chk("bp_head_data", 32'(rsp_data), head_d);
    chk("bp_head_tag", 32'(rsp_tag), head_t);
    chk("bp_head_model", 32'(rsp_data), q[0].d);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("bp_drained", q.size(), 0);
    chk("bp_rsp_valid", 32'(rsp_valid), 0);

    // Pointer wrap: 3*DEPTH rotr, random consumer
    base = takes;
    cnt = 0;
    for (int i = 0; i < 300 && (cnt < 12 || q.size() != 0); i++) begin
      if (cnt < 12) drive(7, 1, 1, 0, cnt);
      else cmd_valid = 1'b0;
      rsp_ready = 1'($urandom_range(1));
      tick();
      if (last_acc) cnt++;
    end
    chk("wrap_rsp_count", takes - base, 12);

    // Random mix with random consumer
    base = takes;
    cnt = 0;
    rand_cmd();
    for (int i = 0; i < 2000 && (cnt < 80 || q.size() != 0); i++) begin
      cmd_valid = (cnt < 80);
      rsp_ready = 1'($urandom_range(1));
      tick();
      if (last_acc) begin
        cnt++;
        rand_cmd();
      end
    end
    cmd_valid = 1'b0;
    chk("rand_rsp_count", takes - base, 80);

    // Reset mid-stream with S1 and FIFO both occupied
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_cmd();
      tick();
    end
    cmd_valid = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    chk("mid_rsp_valid", 32'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("post_no_stale", 32'(rsp_valid), 0);
    base = takes;
    drive(6, 4, 16'h1234, 0, 9);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("post_rsp_data", 32'(rsp_data), 16'h2341);
    tick();
    chk("post_takes", takes - base, 1);
    chk("post_opcnt", 32'(op_count), 1);

    // Counter wrap after 65536 handshakes from reset
    hard_reset();
    chk("cw_start", 32'(op_count), 0);
    rsp_ready = 1'b1;
    base = takes;
    cnt = 0;
    for (int i = 0; i < 70000 && takes - base < 65536; i++) begin
      if (cnt < 65536) drive(0, 0, cnt, 1, cnt);
      else cmd_valid = 1'b0;
      tick();
      if (last_acc) cnt++;
      if (takes - base == 65535) chk("cw_max", 32'(op_count), 16'hFFFF);
    end
    cmd_valid = 1'b0;
    chk("cw_takes", takes - base, 65536);
    chk("cw_wrapped", 32'(op_count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
